// File: rtl/gray_counter_4b.sv
// Gray-code up counter with async clear/preset and terminal-count flag.
// Define GRAY_UPDN_EN to add the up/down direction input.
module gray_counter_4b #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cten,
  input  logic             prs,
`ifdef GRAY_UPDN_EN
  input  logic             up,
`endif
  output logic [WIDTH-1:0] out,
  output logic             tc
);

  localparam logic [WIDTH-1:0] TERM =
    {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       rel_q;
  logic             run;
  logic             dn;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] bin_nx;
  logic             hit;

`ifdef GRAY_UPDN_EN
  assign dn  = ~up;
  assign hit = up ? (out_q == TERM)
                  : (out_q == '0);
`else
  assign dn  = 1'b0;
  assign hit = (out_q == TERM);
`endif

  assign run = rel_q[1];
  assign out = out_q;
  assign tc  = cten & clr & hit;

  // Clear release is retimed to clk so the first count lands cleanly.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) rel_q <= 2'b00;
    else      rel_q <= {rel_q[0], 1'b1};
  end

  // Gray to binary, step, then back to Gray.
  always_comb begin
    bin = '0;
    bin[WIDTH-1] = out_q[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ out_q[i];
    end
    bin_nx = dn ? bin - WIDTH'(1)
                : bin + WIDTH'(1);
    out_d  = bin_nx ^ (bin_nx >> 1);
  end

  // Count register; clear beats preset, both act without a clock.
  always_ff @(posedge clk or negedge clr or negedge prs) begin
    if (!clr)             out_q <= '0;
    else if (!prs)        out_q <= TERM;
    else if (cten && run) out_q <= out_d;
  end

endmodule

// File: tb/tb_gray_counter_4b.sv
// Directed bench for gray_counter_4b.
// Expected values are hand-written Gray codes.
`timescale 1ns/1ps
module tb_gray_counter_4b;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       cten = 1'b1;
  logic       prs = 1'b1;
`ifdef GRAY_UPDN_EN
  logic       up = 1'b1;
`endif
  logic [3:0] out;
  logic       tc;

  int checks = 0;
  int errors = 0;

  logic [3:0] seq [16] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0111, 4'b0101, 4'b0100,
    4'b1100, 4'b1101, 4'b1111, 4'b1110,
    4'b1010, 4'b1011, 4'b1001, 4'b1000
  };

  gray_counter_4b #(.WIDTH(4)) dut (
    .clk  (clk),
    .clr  (clr),
    .cten (cten),
    .prs  (prs),
`ifdef GRAY_UPDN_EN
    .up   (up),
`endif
    .out  (out),
    .tc   (tc)
  );

  always #2 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b",
             tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] prev;

    // async clear, no edge needed
    #1 clr = 1'b0;
    #1;
    chk("clr_async", out, 4'b0000);
    #3;
    chk("clr_hold", out, 4'b0000);
    chk("clr_tc", {3'b0, tc}, 4'd0);

    // release clear, stay idle
    edge1();
    cten = 1'b0;
    clr  = 1'b1;
    repeat (3) edge1();
    chk("release", out, 4'b0000);

    // full sequence plus wrap
    cten = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("tc_seq", {3'b0, tc},
          (i == 15) ? 4'd1 : 4'd0);
      prev = out;
      edge1();
      chk("seq", out, seq[(i + 1) % 16]);
      chk("onebit",
          4'($countones(out ^ prev)), 4'd1);
    end

    // advance to 0110
    repeat (4) edge1();
    chk("to_0110", out, 4'b0110);

    // hold for 100 edges
    cten = 1'b0;
    for (int i = 0; i < 100; i++) begin
      edge1();
      chk("hold", out, 4'b0110);
      chk("hold_tc", {3'b0, tc}, 4'd0);
    end
    cten = 1'b1;
    edge1();
    chk("resume", out, 4'b0111);

    // preset pulse between edges
    #0.5 prs = 1'b0;
    #0.5;
    chk("preset", out, 4'b1000);
    chk("preset_tc", {3'b0, tc}, 4'd1);
    prs = 1'b1;
    edge1();
    chk("after_prs", out, 4'b0000);

    // reach 0101, then clr+prs together
    repeat (6) edge1();
    chk("to_0101", out, 4'b0101);
    #0.5;
    clr = 1'b0;
    prs = 1'b0;
    #0.5;
    chk("clr_prs", out, 4'b0000);
    chk("clr_prs_tc", {3'b0, tc}, 4'd0);
    prs = 1'b1;
    edge1();
    chk("prs_rel", out, 4'b0000);
    clr = 1'b1;
    repeat (2) edge1();
    chk("clr_rel", out, 4'b0000);
    edge1();
    chk("first_cnt", out, 4'b0001);

`ifdef GRAY_UPDN_EN
    // count down through zero
    up = 1'b0;
    #0.5;
    chk("dn_tc0", {3'b0, tc}, 4'd0);
    edge1();
    chk("dn0", out, 4'b0000);
    chk("dn_tc1", {3'b0, tc}, 4'd1);
    edge1();
    chk("dn1", out, 4'b1000);
    chk("dn_tc2", {3'b0, tc}, 4'd0);
    edge1();
    chk("dn2", out, 4'b1001);
    edge1();
    chk("dn3", out, 4'b1011);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
